usb_tx_packet_sequencer: RTL and testbench
==========================================

// Module: usb_tx_packet_sequencer
// PURPOSE
//  Parametrised USB full-speed TX packet sequencer. Selects each byte handed to the TX shift register:
//  SYNC, PID, payload from the TX FIFO, CRC16, then EOP. Adds DATA1, CRC16 append, payload cap,
//  invalid-PID rejection and bit-timed EOP. Sits between the TX FIFO and the bit shifter/NRZI stage.
// PARAMETERS
//  SYNC_BYTE    8'h80  byte sent as SYNC (LSB first)
//  MAX_PAYLOAD  64     max data bytes per packet; further bytes stay in the FIFO
//  OCC_W        7      width of buffer_occupancy
//  EOP_BITS     3      bit times is_eop is held (SE0,SE0,J)
// PORTS
//  clk               in   1      clock
//  n_rst             in   1      reset, asynchronous, active-low
//  begin_packet      in   1      start request; sampled only in IDLE
//  tx_packet         in   3      1=DATA0 2=ACK 3=NAK 4=STALL 5=DATA1; 0,6,7 invalid
//  tx_packet_data    in   8      TX FIFO head byte
//  buffer_occupancy  in   OCC_W  bytes in TX FIFO
//  byte_done         in   1      shifter finished current byte (1-cycle pulse)
//  bit_strobe        in   1      one pulse per bit time
//  shift_data        out  8      byte for shifter; valid when load_byte=1, held until next load
//  load_byte         out  1      1-cycle pulse: shifter captures shift_data
//  get_tx_data       out  1      1-cycle FIFO pop, coincident with each data-byte load
//  is_eop            out  1      drive SE0/J EOP sequence
//  end_packet        out  1      1-cycle pulse when packet complete
//  busy              out  1      high from SYNC load through end_packet
//  err_pid           out  1      1-cycle pulse: begin_packet with invalid tx_packet
// BEHAVIOUR
//  - All outputs registered; reset value 0 for every output, state=IDLE, CRC=16'hFFFF, counters 0.
//  - States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
//  - IDLE: begin_packet & valid type at cycle N -> latch type; SYNC at N+1 with load_byte=1,
//    shift_data=SYNC_BYTE, busy=1. Invalid type -> err_pid at N+1, stay IDLE.
//  - Each byte state advances on byte_done; next load_byte one cycle after byte_done.
//  - SYNC -> PID. PID bytes: DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E.
//  - PID -> EOP for handshake types; data types -> DATA if occupancy>0, else CRC_LO.
//  - DATA: load tx_packet_data with get_tx_data=1; fold byte into CRC; count++.
//    On byte_done: occupancy>0 & count<MAX_PAYLOAD -> next DATA, else CRC_LO.
//  - CRC16: reflected poly 16'hA001, init FFFF, per byte LSB first; CRC_LO sends ~crc[7:0],
//    CRC_HI sends ~crc[15:8]. Zero-length packet sends 00,00.
//  - EOP: is_eop=1, load_byte=0; count bit_strobe; after EOP_BITS strobes -> DONE.
//  - DONE: end_packet=1 one cycle, is_eop=0, busy=0, CRC re-init -> IDLE.
//  - begin_packet while busy ignored (no err_pid). byte_done outside byte states ignored.
//    bit_strobe outside EOP ignored. byte_done+bit_strobe same cycle: each affects only its own state.
//  - Count width $clog2(MAX_PAYLOAD+1); occupancy compare unsigned; no pop at occupancy 0.
//  - Reset mid-packet: immediate IDLE, all outputs 0; no end_packet generated.
// STRUCTURE
//  - Package usb_tx_pkg: state enum, tx_packet codes, PID byte constants, CRC16 poly/init,
//    function crc16_byte(crc,byte) shared by RTL and bench model.
//  - Sub-module usb_crc16: byte-wide CRC16 register with init/enable; data reaches it only via DATA.
//  - Top: FSM, payload counter, EOP bit counter, output registers.
// TESTING
//  - ACK: tx_packet=2 -> loads 80,D2; no get_tx_data; is_eop for 3 strobes; one end_packet.
//  - DATA0 zero-length, occupancy 0 -> loads 80,C3,00,00; EOP; end_packet.
//  - DATA1 bytes 00,01,02,03 -> loads 80,4B,00..03, 4 pops, CRC bytes match crc16_byte model.
//  - MAX_PAYLOAD=4, occupancy 10 -> exactly 4 pops then CRC_LO/HI; FIFO keeps 6 bytes.
//  - tx_packet=0 with begin_packet -> err_pid pulse, busy=0; begin_packet mid-packet ignored.
//  - n_rst low during 2nd data byte -> all outputs 0; next DATA0 packet CRC from fresh FFFF.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types, protocol constants and CRC16 helper for the USB full-speed TX packet sequencer.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrcLo,
        StCrcHi,
        StEop,
        StDone
    } tx_state_e;

    localparam logic [2:0] TxData0 = 3'd1;
    localparam logic [2:0] TxAck   = 3'd2;
    localparam logic [2:0] TxNak   = 3'd3;
    localparam logic [2:0] TxStall = 3'd4;
    localparam logic [2:0] TxData1 = 3'd5;

    localparam logic [7:0] PidData0 = 8'hC3;
    localparam logic [7:0] PidData1 = 8'h4B;
    localparam logic [7:0] PidAck   = 8'hD2;
    localparam logic [7:0] PidNak   = 8'h5A;
    localparam logic [7:0] PidStall = 8'h1E;

    localparam logic [15:0] Crc16Poly = 16'hA001;
    localparam logic [15:0] Crc16Init = 16'hFFFF;

    // Reflected CRC16, data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ Crc16Poly) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [2:0] kind);
        logic [7:0] pid;
        case (kind)
            TxData0: pid = PidData0;
            TxData1: pid = PidData1;
            TxAck:   pid = PidAck;
            TxNak:   pid = PidNak;
            TxStall: pid = PidStall;
            default: pid = 8'h00;
        endcase
        return pid;
    endfunction

    function automatic logic type_valid(input logic [2:0] kind);
        return (kind >= TxData0) && (kind <= TxData1);
    endfunction

    function automatic logic type_is_data(input logic [2:0] kind);
        return (kind == TxData0) || (kind == TxData1);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide CRC16 accumulator; init has priority over enable.
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = Crc16Init;
        end else if (en) begin
            crc_d = crc16_byte(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= Crc16Init;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_tx_packet_sequencer.sv
// USB full-speed TX packet sequencer: SYNC, PID, capped payload, CRC16 and bit-timed EOP,
// feeding one byte at a time to the bit shifter.
module usb_tx_packet_sequencer
    import usb_tx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = 8'h80,
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned OCC_W       = 7,
    parameter int unsigned EOP_BITS    = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             begin_packet,
    input  logic [2:0]       tx_packet,
    input  logic [7:0]       tx_packet_data,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             byte_done,
    input  logic             bit_strobe,
    output logic [7:0]       shift_data,
    output logic             load_byte,
    output logic             get_tx_data,
    output logic             is_eop,
    output logic             end_packet,
    output logic             busy,
    output logic             err_pid
);

    localparam int unsigned CntW = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned EopW = $clog2(EOP_BITS + 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_PAYLOAD);
    localparam logic [EopW-1:0] EopLast = EopW'(EOP_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [2:0]      type_q, type_d;
    logic [CntW-1:0] count_q, count_d;
    logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
    logic [7:0]      shift_data_q, shift_data_d;
    logic            load_byte_q, load_byte_d;
    logic            get_tx_data_q, get_tx_data_d;
    logic            is_eop_q, is_eop_d;
    logic            end_packet_q, end_packet_d;
    logic            busy_q, busy_d;
    logic            err_pid_q, err_pid_d;

    logic            crc_init, crc_en;
    logic [15:0]     crc;
    logic [15:0]     crc_inv;
    logic            have_data;
    logic            next_data, next_crc_lo;

    usb_crc16 u_crc16 (
        .clk   (clk),
        .n_rst (n_rst),
        .init  (crc_init),
        .en    (crc_en),
        .data  (tx_packet_data),
        .crc   (crc)
    );

    assign crc_inv   = ~crc;
    assign have_data = (buffer_occupancy != '0);

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        count_d       = count_q;
        eop_cnt_d     = eop_cnt_q;
        shift_data_d  = shift_data_q;
        load_byte_d   = 1'b0;
        get_tx_data_d = 1'b0;
        is_eop_d      = is_eop_q;
        end_packet_d  = 1'b0;
        busy_d        = busy_q;
        err_pid_d     = 1'b0;
        crc_init      = 1'b0;
        crc_en        = 1'b0;
        next_data     = 1'b0;
        next_crc_lo   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (begin_packet) begin
                    if (type_valid(tx_packet)) begin
                        state_d      = StSync;
                        type_d       = tx_packet;
                        count_d      = '0;
                        eop_cnt_d    = '0;
                        load_byte_d  = 1'b1;
                        shift_data_d = SYNC_BYTE;
                        busy_d       = 1'b1;
                    end else begin
                        err_pid_d = 1'b1;
                    end
                end
            end
            StSync: begin
                if (byte_done) begin
                    state_d      = StPid;
                    load_byte_d  = 1'b1;
                    shift_data_d = pid_byte(type_q);
                end
            end
            StPid: begin
                if (byte_done) begin
                    if (!type_is_data(type_q)) begin
                        state_d   = StEop;
                        is_eop_d  = 1'b1;
                        eop_cnt_d = '0;
                    end else if (have_data) begin
                        next_data = 1'b1;
                    end else begin
                        next_crc_lo = 1'b1;
                    end
                end
            end
            StData: begin
                if (byte_done) begin
                    if (have_data && (count_q < MaxCnt)) begin
                        next_data = 1'b1;
                    end else begin
                        next_crc_lo = 1'b1;
                    end
                end
            end
            StCrcLo: begin
                if (byte_done) begin
                    state_d      = StCrcHi;
                    load_byte_d  = 1'b1;
                    shift_data_d = crc_inv[15:8];
                end
            end
            StCrcHi: begin
                if (byte_done) begin
                    state_d   = StEop;
                    is_eop_d  = 1'b1;
                    eop_cnt_d = '0;
                end
            end
            StEop: begin
                if (bit_strobe) begin
                    if (eop_cnt_q == EopLast) begin
                        state_d      = StDone;
                        is_eop_d     = 1'b0;
                        busy_d       = 1'b0;
                        end_packet_d = 1'b1;
                    end else begin
                        eop_cnt_d = eop_cnt_q + EopW'(1);
                    end
                end
            end
            StDone: begin
                state_d  = StIdle;
                crc_init = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // The CRC register has already absorbed every loaded payload byte by the time we get here.
        if (next_data) begin
            state_d       = StData;
            load_byte_d   = 1'b1;
            shift_data_d  = tx_packet_data;
            get_tx_data_d = 1'b1;
            crc_en        = 1'b1;
            count_d       = count_q + CntW'(1);
        end
        if (next_crc_lo) begin
            state_d      = StCrcLo;
            load_byte_d  = 1'b1;
            shift_data_d = crc_inv[7:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            type_q        <= 3'd0;
            count_q       <= '0;
            eop_cnt_q     <= '0;
            shift_data_q  <= 8'h00;
            load_byte_q   <= 1'b0;
            get_tx_data_q <= 1'b0;
            is_eop_q      <= 1'b0;
            end_packet_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_pid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            count_q       <= count_d;
            eop_cnt_q     <= eop_cnt_d;
            shift_data_q  <= shift_data_d;
            load_byte_q   <= load_byte_d;
            get_tx_data_q <= get_tx_data_d;
            is_eop_q      <= is_eop_d;
            end_packet_q  <= end_packet_d;
            busy_q        <= busy_d;
            err_pid_q     <= err_pid_d;
        end
    end

    assign shift_data  = shift_data_q;
    assign load_byte   = load_byte_q;
    assign get_tx_data = get_tx_data_q;
    assign is_eop      = is_eop_q;
    assign end_packet  = end_packet_q;
    assign busy        = busy_q;
    assign err_pid     = err_pid_q;

endmodule

// File: tb/tb_usb_tx_packet_sequencer.sv
// Scoreboard bench for usb_tx_packet_sequencer with a FIFO and shifter model around the DUT.
module tb_usb_tx_packet_sequencer;
    import usb_tx_pkg::*;

    localparam int unsigned MaxPayload = 4;
    localparam int unsigned OccW       = 7;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            begin_packet = 1'b0;
    logic [2:0]      tx_packet = 3'd0;
    logic [7:0]      tx_packet_data = 8'h00;
    logic [OccW-1:0] buffer_occupancy = '0;
    logic            byte_done = 1'b0;
    logic            bit_strobe = 1'b0;
    logic [7:0]      shift_data;
    logic            load_byte, get_tx_data, is_eop, end_packet, busy, err_pid;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fifo[$];
    int         pops = 0, ends = 0, errs = 0, eop_strobes = 0;
    int         byte_timer = 0, strobe_div = 0;

    always #5 clk = ~clk;

    usb_tx_packet_sequencer #(
        .SYNC_BYTE   (8'h80),
        .MAX_PAYLOAD (MaxPayload),
        .OCC_W       (OccW),
        .EOP_BITS    (3)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .begin_packet     (begin_packet),
        .tx_packet        (tx_packet),
        .tx_packet_data   (tx_packet_data),
        .buffer_occupancy (buffer_occupancy),
        .byte_done        (byte_done),
        .bit_strobe       (bit_strobe),
        .shift_data       (shift_data),
        .load_byte        (load_byte),
        .get_tx_data      (get_tx_data),
        .is_eop           (is_eop),
        .end_packet       (end_packet),
        .busy             (busy),
        .err_pid          (err_pid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pid(input logic [2:0] t);
        case (t)
            3'd1:    return 8'hC3;
            3'd2:    return 8'hD2;
            3'd3:    return 8'h5A;
            3'd4:    return 8'h1E;
            3'd5:    return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    // FIFO + shifter + bit-clock model, sampling DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (load_byte) begin
            check_eq("load_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_eq("shift_data", {24'd0, shift_data}, {24'd0, exp_q.pop_front()});
            byte_timer = 3;
        end
        if (get_tx_data) begin
            check_eq("pop_nonempty", {31'd0, fifo.size() != 0}, 32'd1);
            check_eq("pop_with_load", {31'd0, load_byte}, 32'd1);
            if (fifo.size() != 0) void'(fifo.pop_front());
            pops++;
        end
        if (end_packet) ends++;
        if (err_pid) errs++;
        if (!n_rst) byte_timer = 0;

        strobe_div = (strobe_div + 1) % 4;
        bit_strobe = (strobe_div == 0);
        if (is_eop && bit_strobe) eop_strobes++;

        byte_done = 1'b0;
        if (byte_timer > 0) begin
            byte_timer--;
            if (byte_timer == 0) byte_done = 1'b1;
        end

        buffer_occupancy = OccW'(fifo.size());
        tx_packet_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_packet(input logic [2:0] t, input int nbytes, input logic [7:0] base,
                                output int npay);
        logic [15:0] crc;
        logic [15:0] ncrc;
        logic [7:0]  b;
        step();
        fifo.delete();
        for (int i = 0; i < nbytes; i++) fifo.push_back(base + 8'(i));
        buffer_occupancy = OccW'(fifo.size());
        tx_packet_data   = (nbytes > 0) ? fifo[0] : 8'h00;
        exp_q.push_back(8'h80);
        exp_q.push_back(exp_pid(t));
        npay = 0;
        if (t == 3'd1 || t == 3'd5) begin
            npay = (nbytes < MaxPayload) ? nbytes : MaxPayload;
            crc  = 16'hFFFF;
            for (int i = 0; i < npay; i++) begin
                b = base + 8'(i);
                exp_q.push_back(b);
                crc = crc16_byte(crc, b);
            end
            ncrc = ~crc;
            exp_q.push_back(ncrc[7:0]);
            exp_q.push_back(ncrc[15:8]);
        end
        eop_strobes  = 0;
        begin_packet = 1'b1;
        tx_packet    = t;
        step();
        begin_packet = 1'b0;
        check_eq("sync_load", {31'd0, load_byte}, 32'd1);
        check_eq("busy_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_packet(input logic [2:0] t, input int nbytes, input logic [7:0] base,
                              input bit poke);
        int npay, ends0, pops0, errs0;
        ends0 = ends;
        pops0 = pops;
        errs0 = errs;
        start_packet(t, nbytes, base, npay);
        for (int c = 0; c < 400 && ends == ends0; c++) begin
            step();
            if (poke && c == 2) begin
                begin_packet = 1'b1;
                tx_packet    = 3'd0;
            end else if (poke && c == 3) begin
                begin_packet = 1'b1;
                tx_packet    = 3'd2;
            end else if (poke && c == 4) begin
                begin_packet = 1'b0;
                tx_packet    = t;
            end
        end
        repeat (3) step();
        check_eq("end_packet_count", ends - ends0, 32'd1);
        check_eq("bytes_left", exp_q.size(), 32'd0);
        check_eq("pop_count", pops - pops0, npay);
        check_eq("eop_strobes", eop_strobes, 32'd3);
        check_eq("fifo_left", fifo.size(), nbytes - npay);
        check_eq("err_pid_count", errs - errs0, 32'd0);
        check_eq("idle_flags", {29'd0, busy, is_eop, load_byte}, 32'd0);
        exp_q.delete();
        fifo.delete();
    endtask

    task automatic bad_type(input logic [2:0] t);
        int errs0;
        errs0 = errs;
        step();
        begin_packet = 1'b1;
        tx_packet    = t;
        step();
        begin_packet = 1'b0;
        check_eq("err_pid_pulse", {31'd0, err_pid}, 32'd1);
        check_eq("err_busy", {30'd0, busy, load_byte}, 32'd0);
        step();
        check_eq("err_pid_clear", {31'd0, err_pid}, 32'd0);
        check_eq("err_pid_count", errs - errs0, 32'd1);
    endtask

    initial begin
        int npay, pops0, ends0;
        repeat (2) step();
        check_eq("reset_outputs", {23'd0, shift_data, load_byte, get_tx_data, is_eop,
                 end_packet, busy, err_pid}, 32'd0);
        n_rst = 1'b1;
        repeat (2) step();

        run_packet(3'd2, 0, 8'h00, 1'b0);  // ACK
        run_packet(3'd1, 0, 8'h00, 1'b0);  // DATA0 zero-length
        run_packet(3'd5, 4, 8'h00, 1'b0);  // DATA1 00..03
        run_packet(3'd1, 10, 8'h15, 1'b0); // payload cap
        bad_type(3'd0);
        bad_type(3'd7);
        run_packet(3'd3, 0, 8'h00, 1'b1);  // NAK with begin_packet pokes while busy
        run_packet(3'd4, 0, 8'h00, 1'b0);  // STALL

        // Reset during the second payload byte.
        pops0 = pops;
        ends0 = ends;
        start_packet(3'd1, 4, 8'h30, npay);
        for (int c = 0; c < 400 && (pops - pops0) < 2; c++) step();
        check_eq("reached_2nd_byte", pops - pops0, 32'd2);
        n_rst = 1'b0;
        #1;
        check_eq("midreset_outputs", {23'd0, shift_data, load_byte, get_tx_data, is_eop,
                 end_packet, busy, err_pid}, 32'd0);
        exp_q.delete();
        fifo.delete();
        repeat (2) step();
        n_rst = 1'b1;
        repeat (4) step();
        check_eq("no_end_after_reset", ends - ends0, 32'd0);
        run_packet(3'd1, 3, 8'hA0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
